tm_multiclass_infer: RTL

Parametrised multi-class Tsetlin Machine inference engine: one shared clause/chunk address sequencer drives external per-class TA-state ROMs and one input-literal ROM. Per-class clause evaluation, polarity-signed vote accumulation, threshold clamping and a sequential argmax run behind a start/done handshake. The engine reports a predicted class and all clamped class sums. It replaces the fixed 10-class, free-running classifier and sits between the TA/XIN ROM banks and the result interface.

---
 rtl/tm_multiclass_infer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/tm_multiclass_infer.sv
// Multi-class Tsetlin Machine inference engine: a shared clause/chunk sequencer feeds
// per-class TA ROMs, and the engine accumulates signed votes, clamps the sums and picks the argmax.
module tm_multiclass_infer #(
  parameter int                 N_CLASSES = 10,
  parameter int                 CLAUSES   = 2000,
  parameter int                 LA_CHUNKS = 49,
  parameter int                 CHUNK_W   = 32,
  parameter logic [CHUNK_W-1:0] FILTER    = {CHUNK_W{1'b1}},
  parameter int                 SUM_W     = 32,
  parameter int                 THRESHOLD = 128,
  parameter int                 CLAUSE_AW = (CLAUSES > 1) ? $clog2(CLAUSES) : 1,
  parameter int                 CHUNK_AW  = (LA_CHUNKS > 1) ? $clog2(LA_CHUNKS) : 1,
  parameter int                 CLASS_W   = $clog2(N_CLASSES)
) (
  input  logic                         clk,
  input  logic                         rst_flag,
  input  logic                         start,
  input  logic                         abort,
  output logic [CLAUSE_AW-1:0]         clause_addr,
  output logic [CHUNK_AW-1:0]          chunk_addr,
  input  logic [N_CLASSES*CHUNK_W-1:0] ta_state,
  input  logic [CHUNK_W-1:0]           xin,
  output logic                         busy,
  output logic                         done,
  output logic [CLASS_W-1:0]           pred_class,
  output logic [SUM_W-1:0]             pred_sum,
  output logic [N_CLASSES*SUM_W-1:0]   class_sums
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_CLAMP  = 3'd2,
    ST_ARGMAX = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [CLAUSE_AW-1:0]    LAST_CLAUSE = CLAUSE_AW'(CLAUSES - 1);
  localparam logic [CHUNK_AW-1:0]     LAST_CHUNK  = CHUNK_AW'(LA_CHUNKS - 1);
  localparam logic [CLASS_W-1:0]      LAST_CLASS  = CLASS_W'(N_CLASSES - 1);
  localparam logic signed [SUM_W-1:0] T_POS       = SUM_W'(THRESHOLD);
  localparam logic signed [SUM_W-1:0] T_NEG       = -T_POS;
  localparam logic signed [SUM_W-1:0] SUM_ONE     = SUM_W'(1);

  state_t                    state_q, state_d;
  logic [CLAUSE_AW-1:0]      clause_q, clause_d;
  logic [CHUNK_AW-1:0]       chunk_q, chunk_d;
  logic [CLASS_W-1:0]        cls_q, cls_d;
  logic [N_CLASSES-1:0]      viol_q, viol_d, inc_q, inc_d;
  logic [N_CLASSES-1:0]      viol_hit_s, inc_hit_s;
  logic [CHUNK_W-1:0]        mask_s;
  logic signed [SUM_W-1:0]   sum_q [N_CLASSES];
  logic signed [SUM_W-1:0]   sum_d [N_CLASSES];
  logic [CLASS_W-1:0]        best_idx_q, best_idx_d;
  logic signed [SUM_W-1:0]   best_sum_q, best_sum_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic [CLASS_W-1:0]        pred_class_q, pred_class_d;
  logic [SUM_W-1:0]          pred_sum_q, pred_sum_d;
  logic [N_CLASSES*SUM_W-1:0] class_sums_q, class_sums_d;
  logic                      start_acc_s, last_cell_s, first_chunk_s, last_chunk_s;

  function automatic logic signed [SUM_W-1:0] clamp_sum(input logic signed [SUM_W-1:0] s);
    if (s > T_POS) begin
      return T_POS;
    end else if (s < T_NEG) begin
      return T_NEG;
    end else begin
      return s;
    end
  endfunction

  assign first_chunk_s = (chunk_q == {CHUNK_AW{1'b0}});
  assign last_chunk_s  = (chunk_q == LAST_CHUNK);
  assign last_cell_s   = last_chunk_s && (clause_q == LAST_CLAUSE);
  // A start during the done pulse is ignored; it is accepted one IDLE cycle later.
  assign start_acc_s   = (state_q == ST_IDLE) && start && !done_q && !abort;

  // Per-class literal hits for the chunk currently addressed.
  always_comb begin
    mask_s     = last_chunk_s ? FILTER : {CHUNK_W{1'b1}};
    viol_hit_s = {N_CLASSES{1'b0}};
    inc_hit_s  = {N_CLASSES{1'b0}};
    for (int c = 0; c < N_CLASSES; c++) begin
      viol_hit_s[c] = |(ta_state[c*CHUNK_W +: CHUNK_W] & ~xin & mask_s);
      inc_hit_s[c]  = |(ta_state[c*CHUNK_W +: CHUNK_W] & mask_s);
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = start_acc_s ? ST_EVAL : ST_IDLE;
        ST_EVAL:   state_d = last_cell_s ? ST_CLAMP : ST_EVAL;
        ST_CLAMP:  state_d = ST_ARGMAX;
        ST_ARGMAX: state_d = (cls_q == LAST_CLASS) ? ST_DONE : ST_ARGMAX;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer, clause evaluation, vote accumulation, clamp and argmax datapath.
  always_comb begin
    clause_d   = clause_q;
    chunk_d    = chunk_q;
    cls_d      = cls_q;
    viol_d     = viol_q;
    inc_d      = inc_q;
    best_idx_d = best_idx_q;
    best_sum_d = best_sum_q;
    for (int c = 0; c < N_CLASSES; c++) begin
      sum_d[c] = sum_q[c];
    end
    if (abort) begin
      clause_d = {CLAUSE_AW{1'b0}};
      chunk_d  = {CHUNK_AW{1'b0}};
    end else if (start_acc_s) begin
      clause_d = {CLAUSE_AW{1'b0}};
      chunk_d  = {CHUNK_AW{1'b0}};
      cls_d    = {CLASS_W{1'b0}};
      viol_d   = {N_CLASSES{1'b0}};
      inc_d    = {N_CLASSES{1'b0}};
      for (int c = 0; c < N_CLASSES; c++) begin
        sum_d[c] = {SUM_W{1'b0}};
      end
    end else if (state_q == ST_EVAL) begin
      if (last_chunk_s) begin
        chunk_d  = {CHUNK_AW{1'b0}};
        clause_d = (clause_q == LAST_CLAUSE) ? {CLAUSE_AW{1'b0}} : clause_q + CLAUSE_AW'(1);
      end else begin
        chunk_d  = chunk_q + CHUNK_AW'(1);
      end
      for (int c = 0; c < N_CLASSES; c++) begin
        viol_d[c] = (first_chunk_s ? 1'b0 : viol_q[c]) | viol_hit_s[c];
        inc_d[c]  = (first_chunk_s ? 1'b0 : inc_q[c]) | inc_hit_s[c];
        // Even clauses vote for the class, odd clauses against it.
        if (last_chunk_s && inc_d[c] && !viol_d[c]) begin
          sum_d[c] = clause_q[0] ? sum_q[c] - SUM_ONE : sum_q[c] + SUM_ONE;
        end else begin
          sum_d[c] = sum_q[c];
        end
      end
    end else if (state_q == ST_CLAMP) begin
      cls_d = {CLASS_W{1'b0}};
      for (int c = 0; c < N_CLASSES; c++) begin
        sum_d[c] = clamp_sum(sum_q[c]);
      end
    end else if (state_q == ST_ARGMAX) begin
      // Strictly-greater replacement keeps the lowest index on ties.
      if ((cls_q == {CLASS_W{1'b0}}) || (sum_q[cls_q] > best_sum_q)) begin
        best_idx_d = cls_q;
        best_sum_d = sum_q[cls_q];
      end else begin
        best_idx_d = best_idx_q;
        best_sum_d = best_sum_q;
      end
      cls_d = (cls_q == LAST_CLASS) ? {CLASS_W{1'b0}} : cls_q + CLASS_W'(1);
    end else begin
      cls_d = cls_q;
    end
  end

  // Handshake flags and result registers, loaded only when a run completes.
  always_comb begin
    busy_d       = busy_q;
    done_d       = 1'b0;
    pred_class_d = pred_class_q;
    pred_sum_d   = pred_sum_q;
    class_sums_d = class_sums_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start_acc_s) begin
      busy_d = 1'b1;
    end else if (state_q == ST_DONE) begin
      busy_d       = 1'b0;
      done_d       = 1'b1;
      pred_class_d = best_idx_q;
      pred_sum_d   = best_sum_q;
      for (int c = 0; c < N_CLASSES; c++) begin
        class_sums_d[c*SUM_W +: SUM_W] = sum_q[c];
      end
    end else begin
      busy_d = busy_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_flag) begin
    if (!rst_flag) begin
      state_q      <= ST_IDLE;
      clause_q     <= {CLAUSE_AW{1'b0}};
      chunk_q      <= {CHUNK_AW{1'b0}};
      cls_q        <= {CLASS_W{1'b0}};
      viol_q       <= {N_CLASSES{1'b0}};
      inc_q        <= {N_CLASSES{1'b0}};
      best_idx_q   <= {CLASS_W{1'b0}};
      best_sum_q   <= {SUM_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pred_class_q <= {CLASS_W{1'b0}};
      pred_sum_q   <= {SUM_W{1'b0}};
      class_sums_q <= {(N_CLASSES*SUM_W){1'b0}};
      for (int c = 0; c < N_CLASSES; c++) begin
        sum_q[c] <= {SUM_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      clause_q     <= clause_d;
      chunk_q      <= chunk_d;
      cls_q        <= cls_d;
      viol_q       <= viol_d;
      inc_q        <= inc_d;
      best_idx_q   <= best_idx_d;
      best_sum_q   <= best_sum_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pred_class_q <= pred_class_d;
      pred_sum_q   <= pred_sum_d;
      class_sums_q <= class_sums_d;
      for (int c = 0; c < N_CLASSES; c++) begin
        sum_q[c] <= sum_d[c];
      end
    end
  end

  assign clause_addr = clause_q;
  assign chunk_addr  = chunk_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pred_class  = pred_class_q;
  assign pred_sum    = pred_sum_q;
  assign class_sums  = class_sums_q;

endmodule
